// File: rtl/rps_pkg.sv
// Shared encodings for the rock-paper-scissors round controller: player choices,
// opponent modes, controller states and the round judging rule.
package rps_pkg;

  typedef enum logic [1:0] {
    ROCK           = 2'b00,
    SCISSOR        = 2'b01,
    PAPER          = 2'b10,
    CHOICE_ILLEGAL = 2'b11
  } choice_t;

  typedef enum logic [1:0] {
    MODE_RANDOM     = 2'b00,
    MODE_MARKOV     = 2'b01,
    MODE_REINFORCE  = 2'b10,
    MODE_RANDOM_ALT = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_READY,
    LATCH,
    SCORE,
    DRAW,
    WAIT_DRAW
  } state_t;

  typedef enum logic [1:0] {
    RES_VOID,
    RES_USER,
    RES_COM,
    RES_TIE
  } result_t;

  function automatic logic beats(input choice_t a, input choice_t b);
    return (a == ROCK    && b == SCISSOR) ||
           (a == SCISSOR && b == PAPER)   ||
           (a == PAPER   && b == ROCK);
  endfunction

  // An illegal choice on either side voids the round before anything else is judged.
  function automatic result_t judge(input choice_t u, input choice_t c);
    if (u == CHOICE_ILLEGAL || c == CHOICE_ILLEGAL) return RES_VOID;
    if (u == c) return RES_TIE;
    if (beats(u, c)) return RES_USER;
    return RES_COM;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes the raw active-low start key, debounces it and emits a one-cycle
// pulse on each accepted press; a key already held down at reset release is ignored.
module key_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic [CW-1:0]          cnt;
  logic                   level;
  logic                   armed;
  logic                   sync_out;
  logic                   chain_valid;
  logic                   accept;

  assign sync_out    = sync_q[SYNC_STAGES-1];
  assign chain_valid = fill_q[SYNC_STAGES-1];
  assign accept      = (sync_out != level) && (cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the synchronizer resets to the released level so reset itself never looks like a press.
      sync_q <= '1;
      fill_q <= '0;
      level  <= 1'b1;
      cnt    <= '0;
      armed  <= 1'b0;
      press  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value of its neighbour.
      sync_q[0] <= key_n;
      fill_q[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
        fill_q[i] <= fill_q[i-1];
      end

      // Only a key seen released after reset may produce presses.
      if (chain_valid && sync_out) armed <= 1'b1;

      press <= accept && !sync_out && armed;

      if (sync_out == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync_out;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/round_controller.sv
// Round sequencer: takes a debounced start press, latches both choices, scores the
// round, asks the display engine to redraw and waits for it to finish.
module round_controller
  import rps_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start_n,
  input  logic [1:0] mode,
  input  logic [1:0] user,
  input  logic [1:0] com_ra,
  input  logic [1:0] com_m,
  input  logic [1:0] com_re,
  input  logic       re_ready,
  input  logic       draw_done,
  output logic [1:0] com_loaded,
  output logic [1:0] user_lat,
  output logic [7:0] user_score,
  output logic [7:0] com_score,
  output logic       uwin,
  output logic       cwin,
  output logic       equ,
  output logic       draw_start,
  output logic       round_done,
  output logic       busy
);

  state_t     state;
  logic       press;
  logic [1:0] com_pick;
  result_t    outcome;

  key_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clock   (clock),
    .reset_n (reset_n),
    .key_n   (start_n),
    .press   (press)
  );

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    com_pick = com_ra;
    case (mode_t'(mode))
      MODE_MARKOV:    com_pick = com_m;
      MODE_REINFORCE: com_pick = com_re;
      default:        com_pick = com_ra;
    endcase
  end

  // Judged from the registers written in LATCH, so SCORE always sees this round's choices.
  assign outcome = judge(choice_t'(user_lat), choice_t'(com_loaded));
  assign busy    = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      com_loaded <= '0;
      user_lat   <= '0;
      user_score <= '0;
      com_score  <= '0;
      uwin       <= 1'b0;
      cwin       <= 1'b0;
      equ        <= 1'b0;
      draw_start <= 1'b0;
      round_done <= 1'b0;
    end else begin
      draw_start <= 1'b0;
      round_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (press) begin
            state <= (mode_t'(mode) == MODE_REINFORCE && !re_ready) ? WAIT_READY : LATCH;
          end
        end
        WAIT_READY: begin
          if (re_ready) state <= LATCH;
        end
        LATCH: begin
          user_lat   <= user;
          com_loaded <= com_pick;
          state      <= SCORE;
        end
        SCORE: begin
          uwin <= (outcome == RES_USER);
          cwin <= (outcome == RES_COM);
          equ  <= (outcome == RES_TIE);
          if (outcome == RES_USER) user_score <= user_score + 8'd1;
          if (outcome == RES_COM)  com_score  <= com_score + 8'd1;
          round_done <= 1'b1;
          draw_start <= 1'b1;
          state      <= DRAW;
        end
        DRAW: begin
          state <= WAIT_DRAW;
        end
        WAIT_DRAW: begin
          if (draw_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
